// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load/store at a time from the MEM stage onto a
// byte-addressed, big-endian data RAM with level-sensitive pins. Doublewords are
// split into two word accesses; every enable pulse is followed by a low cycle.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req, rw, size, signed_ld     request strobe and attributes
//   addr, wdata0, wdata1         byte address and store data
//   busy, done, err              status (done/err are one-cycle pulses)
//   rdata0, rdata1               load results
//   ram_enable, ram_rw, ram_addr, ram_din, ram_mode   registered RAM pins
//   ram_dout                     RAM read data
module mem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        signed_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        ram_enable,
  output logic        ram_rw,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic [1:0]  ram_mode,
  input  logic [31:0] ram_dout
);

  typedef enum logic [2:0] {IDLE, A1, C1, A2, C2, DONE} state_t;

  state_t      state, state_d;
  logic        busy_d, done_d, err_d, en_d, rw_d, accept;
  logic [31:0] addr_d, din_d;
  logic [1:0]  mode_d;

  logic        l_rw, l_signed;
  logic [1:0]  l_size;
  logic [31:0] l_addr, l_wd0, l_wd1;

  logic [3:0]  last_off;
  logic [32:0] last_byte;
  logic        misalign, out_of_range;
  logic [31:0] ld_fmt;

  // Request legality: alignment and last-byte range check in 33 bits
  always_comb begin
    case (size)
      2'b00:   last_off = 4'd0;
      2'b01:   last_off = 4'd1;
      2'b10:   last_off = 4'd3;
      default: last_off = 4'd7;
    endcase
    last_byte    = {1'b0, addr} + 33'(last_off);
    misalign     = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    out_of_range = last_byte >= 33'(MEM_BYTES);
  end

  // Load formatting applied when capturing the first RAM word
  always_comb begin
    case (l_size)
      2'b00:   ld_fmt = {{24{l_signed & ram_dout[7]}}, ram_dout[7:0]};
      2'b01:   ld_fmt = {{16{l_signed & ram_dout[15]}}, ram_dout[15:0]};
      default: ld_fmt = ram_dout;
    endcase
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    err_d   = 1'b0;
    en_d    = 1'b0;
    rw_d    = ram_rw;
    addr_d  = ram_addr;
    din_d   = ram_din;
    mode_d  = ram_mode;
    case (state)
      // DONE also samples req so back-to-back singles take 3 cycles
      IDLE, DONE: begin
        state_d = IDLE;
        if (req) begin
          if (misalign || out_of_range) begin
            err_d = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = A1;
            en_d    = 1'b1;
            rw_d    = rw;
            addr_d  = addr;
            din_d   = wdata0;
            mode_d  = (size == 2'b11) ? 2'b10 : size;
          end
        end
      end
      A1: state_d = C1;
      C1: begin
        if (l_size == 2'b11) begin
          state_d = A2;
          en_d    = 1'b1;
          addr_d  = l_addr + 32'd4;
          din_d   = l_wd1;
          mode_d  = 2'b10;
        end else begin
          state_d = DONE;
        end
      end
      A2:      state_d = C2;
      C2:      state_d = DONE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, registered outputs, request latches and load capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ram_enable <= 1'b0;
      ram_rw     <= 1'b0;
      ram_addr   <= 32'd0;
      ram_din    <= 32'd0;
      ram_mode   <= 2'b00;
      rdata0     <= 32'd0;
      rdata1     <= 32'd0;
      l_rw       <= 1'b0;
      l_signed   <= 1'b0;
      l_size     <= 2'b00;
      l_addr     <= 32'd0;
      l_wd0      <= 32'd0;
      l_wd1      <= 32'd0;
    end else begin
      state      <= state_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      ram_enable <= en_d;
      ram_rw     <= rw_d;
      ram_addr   <= addr_d;
      ram_din    <= din_d;
      ram_mode   <= mode_d;
      if (accept) begin
        l_rw     <= rw;
        l_signed <= signed_ld;
        l_size   <= size;
        l_addr   <= addr;
        l_wd0    <= wdata0;
        l_wd1    <= wdata1;
      end
      if ((state == C1) && !l_rw) begin
        rdata0 <= ld_fmt;
        rdata1 <= 32'd0;
      end
      if ((state == C2) && !l_rw) begin
        rdata1 <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a behavioural big-endian 256x8 RAM.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, rw, signed_ld;
  logic [1:0]  size;
  logic [31:0] addr, wdata0, wdata1;
  logic        busy, done, err;
  logic [31:0] rdata0, rdata1;
  logic        ram_enable, ram_rw;
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic [1:0]  ram_mode;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .size(size),
    .signed_ld(signed_ld), .addr(addr), .wdata0(wdata0), .wdata1(wdata1),
    .busy(busy), .done(done), .err(err), .rdata0(rdata0), .rdata1(rdata1),
    .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_mode(ram_mode), .ram_dout(ram_dout)
  );

  // RAM model: reads follow the pins, writes happen once per enable pulse
  logic [7:0] mem [256];
  logic       ram_en_q = 1'b0;
  logic [7:0] a0_8, a1_8, a2_8, a3_8;

  always_comb begin
    a0_8 = ram_addr[7:0];
    a1_8 = a0_8 + 8'd1;
    a2_8 = a0_8 + 8'd2;
    a3_8 = a0_8 + 8'd3;
    case (ram_mode)
      2'b00:   ram_dout = {24'd0, mem[a0_8]};
      2'b01:   ram_dout = {16'd0, mem[a0_8], mem[a1_8]};
      default: ram_dout = {mem[a0_8], mem[a1_8], mem[a2_8], mem[a3_8]};
    endcase
  end

  always @(negedge clk) begin
    if (ram_enable && !ram_en_q && ram_rw) begin
      case (ram_mode)
        2'b00: mem[a0_8] <= ram_din[7:0];
        2'b01: begin
          mem[a0_8] <= ram_din[15:8];
          mem[a1_8] <= ram_din[7:0];
        end
        default: begin
          mem[a0_8] <= ram_din[31:24];
          mem[a1_8] <= ram_din[23:16];
          mem[a2_8] <= ram_din[15:8];
          mem[a3_8] <= ram_din[7:0];
        end
      endcase
    end
    ram_en_q <= ram_enable;
  end

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        exp_err;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
  } vec_t;

  vec_t vecs [17];
  vec_t sbq [$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic [1:0] s, logic g, logic [31:0] a,
                              logic [31:0] w0, logic [31:0] w1, logic e,
                              logic [31:0] r0, logic [31:0] r1);
    vec_t v;
    v.rw = r; v.size = s; v.sgn = g; v.addr = a; v.wd0 = w0; v.wd1 = w1;
    v.exp_err = e; v.exp_rd0 = r0; v.exp_rd1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int          n_en, n_done, n_err, done_cyc;
    logic        busy_seen, prev;
    logic [31:0] pa0, pa1;
    logic [1:0]  pm0;
    vec_t        e;
    n_en = 0; n_done = 0; n_err = 0; done_cyc = 0;
    busy_seen = 1'b0; pa0 = '0; pa1 = '0; pm0 = '0;
    @(negedge clk);
    rw = v.rw; size = v.size; signed_ld = v.sgn; addr = v.addr;
    wdata0 = v.wd0; wdata1 = v.wd1; req = 1'b1;
    sbq.push_back(v);
    prev = ram_enable;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      req = 1'b0;
      if (ram_enable && !prev) begin
        if (n_en == 0) begin pa0 = ram_addr; pm0 = ram_mode; end
        else pa1 = ram_addr;
        n_en++;
      end
      prev = ram_enable;
      if (busy) busy_seen = 1'b1;
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) n_err++;
      if (done || err) begin
        if (sbq.size() == 0) begin
          chk({tag, " unexpected_completion"}, 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk({tag, " err_flag"}, 32'(err), 32'(e.exp_err));
          chk({tag, " rdata0"}, rdata0, e.exp_rd0);
          chk({tag, " rdata1"}, rdata1, e.exp_rd1);
        end
      end
    end
    if (sbq.size() != 0) begin
      sbq.delete();
      chk({tag, " completion_timeout"}, 32'd0, 32'd1);
    end
    chk({tag, " enable_pulses"}, 32'(n_en), v.exp_err ? 32'd0 : ((v.size == 2'b11) ? 32'd2 : 32'd1));
    chk({tag, " done_pulses"}, 32'(n_done), v.exp_err ? 32'd0 : 32'd1);
    chk({tag, " err_pulses"}, 32'(n_err), v.exp_err ? 32'd1 : 32'd0);
    chk({tag, " busy_seen"}, 32'(busy_seen), v.exp_err ? 32'd0 : 32'd1);
    if (!v.exp_err) begin
      chk({tag, " done_cycle"}, 32'(done_cyc), (v.size == 2'b11) ? 32'd5 : 32'd3);
      chk({tag, " addr_first"}, pa0, v.addr);
      chk({tag, " mode_first"}, 32'(pm0), (v.size == 2'b11) ? 32'd2 : 32'(v.size));
      if (v.size == 2'b11) chk({tag, " addr_second"}, pa1, v.addr + 32'd4);
    end
  endtask

  initial begin
    int nd, ne;
    logic pe;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    mem[5] = 8'h80; mem[6] = 8'h80; mem[7] = 8'h01;
    req = 0; rw = 0; size = 0; signed_ld = 0; addr = 0; wdata0 = 0; wdata1 = 0;
    rst_n = 1'b0;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset ram_enable", 32'(ram_enable), 32'd0);
    chk("reset ram_addr", ram_addr, 32'd0);
    chk("reset ram_mode", 32'(ram_mode), 32'd0);
    chk("reset rdata0", rdata0, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vecs[0]  = mk(0, 2'b10, 0, 32'd0,   0, 0, 0, 32'h01020304, 32'h0);
    vecs[1]  = mk(0, 2'b00, 1, 32'd5,   0, 0, 0, 32'hFFFFFF80, 32'h0);
    vecs[2]  = mk(0, 2'b00, 0, 32'd5,   0, 0, 0, 32'h00000080, 32'h0);
    vecs[3]  = mk(0, 2'b01, 1, 32'd6,   0, 0, 0, 32'hFFFF8001, 32'h0);
    vecs[4]  = mk(0, 2'b01, 0, 32'd6,   0, 0, 0, 32'h00008001, 32'h0);
    vecs[5]  = mk(1, 2'b11, 0, 32'd8,   32'hAAAAAAAA, 32'h55555555, 0, 32'h00008001, 32'h0);
    vecs[6]  = mk(0, 2'b11, 0, 32'd8,   0, 0, 0, 32'hAAAAAAAA, 32'h55555555);
    vecs[7]  = mk(0, 2'b01, 0, 32'd3,   0, 0, 1, 32'hAAAAAAAA, 32'h55555555);
    vecs[8]  = mk(0, 2'b10, 0, 32'd6,   0, 0, 1, 32'hAAAAAAAA, 32'h55555555);
    vecs[9]  = mk(0, 2'b10, 0, 32'd254, 0, 0, 1, 32'hAAAAAAAA, 32'h55555555);
    vecs[10] = mk(0, 2'b11, 0, 32'd252, 0, 0, 1, 32'hAAAAAAAA, 32'h55555555);
    vecs[11] = mk(1, 2'b00, 0, 32'd255, 32'h1234567F, 0, 0, 32'hAAAAAAAA, 32'h55555555);
    vecs[12] = mk(0, 2'b00, 0, 32'd255, 0, 0, 0, 32'h0000007F, 32'h0);
    vecs[13] = mk(0, 2'b00, 0, 32'd256, 0, 0, 1, 32'h0000007F, 32'h0);
    vecs[14] = mk(1, 2'b10, 0, 32'd252, 32'hDEADBEEF, 0, 0, 32'h0000007F, 32'h0);
    vecs[15] = mk(0, 2'b01, 1, 32'd254, 0, 0, 0, 32'hFFFFBEEF, 32'h0);
    vecs[16] = mk(0, 2'b10, 1, 32'd252, 0, 0, 0, 32'hDEADBEEF, 32'h0);

    for (int i = 0; i < 17; i++) run_txn(vecs[i], $sformatf("vec%0d", i));
    chk("dword store bytes 8..11", {mem[8], mem[9], mem[10], mem[11]}, 32'hAAAAAAAA);
    chk("dword store bytes 12..15", {mem[12], mem[13], mem[14], mem[15]}, 32'h55555555);

    // req held for six edges with word loads: only IDLE/DONE edges accept
    nd = 0; ne = 0; pe = 1'b0;
    @(negedge clk);
    rw = 0; size = 2'b10; signed_ld = 0; addr = 32'd0; req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 6) req = 1'b0;
      if (ram_enable && !pe) ne++;
      pe = ram_enable;
      if (done) begin
        nd++;
        chk("held_req rdata0", rdata0, 32'h01020304);
      end
    end
    chk("held_req done_pulses", 32'(nd), 32'd2);
    chk("held_req enable_pulses", 32'(ne), 32'd2);

    // Reset between the two halves of a dword store
    for (int i = 8; i < 16; i++) mem[i] = 8'h00;
    @(negedge clk);
    rw = 1; size = 2'b11; addr = 32'd8; wdata0 = 32'h11223344; wdata1 = 32'h55667788;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("rst_seq first pulse", 32'(ram_enable), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_seq busy", 32'(busy), 32'd0);
    chk("rst_seq ram_enable", 32'(ram_enable), 32'd0);
    chk("rst_seq ram_rw", 32'(ram_rw), 32'd0);
    chk("rst_seq ram_addr", ram_addr, 32'd0);
    chk("rst_seq ram_din", ram_din, 32'd0);
    chk("rst_seq rdata0", rdata0, 32'd0);
    nd = 0; ne = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) nd++;
      if (ram_enable) ne++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) nd++;
      if (ram_enable) ne++;
    end
    chk("rst_seq no_done", 32'(nd), 32'd0);
    chk("rst_seq no_enable", 32'(ne), 32'd0);
    chk("rst_seq bytes 8..11", {mem[8], mem[9], mem[10], mem[11]}, 32'h11223344);
    chk("rst_seq bytes 12..15", {mem[12], mem[13], mem[14], mem[15]}, 32'h00000000);
    run_txn(mk(0, 2'b11, 0, 32'd8, 0, 0, 0, 32'h11223344, 32'h0), "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
